// File: rtl/change_dispenser_pkg.sv
// Shared types and constants for the vending-machine coin-return path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vend_pkg;

    // Coin denomination index: 0 = smallest coin, 3 = largest coin
    typedef logic [1:0] coin_idx_t;

    // Default coin face values, indexed by coin_idx_t
    localparam int DEF_COIN3_VAL = 20;
    localparam int DEF_COIN2_VAL = 10;
    localparam int DEF_COIN1_VAL = 5;
    localparam int DEF_COIN0_VAL = 1;

    // Largest credit the purchase side can accumulate
    localparam int DEF_MAX_BALANCE = 79;

    // Hopper settle time between coins
    localparam int DEF_GAP_CYCLES = 2;

    // Payout sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        ISSUE  = 3'd2,
        GAP    = 3'd3,
        DONE   = 3'd4
    } disp_state_t;

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Greedy coin picker: highest available denomination not exceeding the credit.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module coin_select
    import vend_pkg::*;
#(
    parameter int COIN3_VAL = DEF_COIN3_VAL,
    parameter int COIN2_VAL = DEF_COIN2_VAL,
    parameter int COIN1_VAL = DEF_COIN1_VAL,
    parameter int COIN0_VAL = DEF_COIN0_VAL
) (
    input  logic [7:0] i_remaining,
    input  logic [3:0] i_avail,
    output coin_idx_t  o_sel,
    output logic       o_found
);

    // Priority search from the largest coin down; found=0 means nothing fits
    always_comb begin
        o_sel   = 2'd0;
        o_found = 1'b0;
        if (i_avail[3] && (i_remaining >= 8'(COIN3_VAL))) begin
            o_sel   = 2'd3;
            o_found = 1'b1;
        end else if (i_avail[2] && (i_remaining >= 8'(COIN2_VAL))) begin
            o_sel   = 2'd2;
            o_found = 1'b1;
        end else if (i_avail[1] && (i_remaining >= 8'(COIN1_VAL))) begin
            o_sel   = 2'd1;
            o_found = 1'b1;
        end else if (i_avail[0] && (i_remaining >= 8'(COIN0_VAL)) && (i_remaining != 8'd0)) begin
            o_sel   = 2'd0;
            o_found = 1'b1;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Breaks a returned credit into coins (largest first) and feeds them to the hopper; optional inventory via CHANGE_INVENTORY_EN.
// Latency: start at cycle N -> first coin_valid at N+2 (zero balance -> done at N+2); GAP_CYCLES idle cycles after every coin.
// Backpressure: coin_valid/coin_sel held until hopper_ready; waits indefinitely, start ignored while busy or in DONE.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int COIN3_VAL   = DEF_COIN3_VAL,
    parameter int COIN2_VAL   = DEF_COIN2_VAL,
    parameter int COIN1_VAL   = DEF_COIN1_VAL,
    parameter int COIN0_VAL   = DEF_COIN0_VAL,
    parameter int MAX_BALANCE = DEF_MAX_BALANCE,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] balance,
    input  logic       hopper_ready,
`ifdef CHANGE_INVENTORY_EN
    input  logic       refill,
    input  logic [1:0] refill_sel,
`endif
    output logic       coin_valid,
    output logic [1:0] coin_sel,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] remaining,
    output logic [3:0] coin_count
);

    disp_state_t r_state;
    disp_state_t w_state_nxt;

    logic [7:0] r_remaining;
    logic [3:0] r_coin_count;
    logic       r_error;
    coin_idx_t  r_coin_sel;
    logic [7:0] r_gap_cnt;

    logic       w_load;
    logic       w_bad_balance;
    logic       w_latch;
    logic       w_xfer;
    logic       w_shortage;
    logic       w_gap_last;
    logic [7:0] w_coin_val;
    logic [3:0] w_avail;
    coin_idx_t  w_sel;
    logic       w_found;

`ifdef CHANGE_INVENTORY_EN
    logic [7:0] r_inv [4];

    // Per-denomination stock: refill adds one (saturating), a transfer takes one; both together cancel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                r_inv[k] <= 8'd0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (refill && (refill_sel == 2'(k)) && !(w_xfer && (r_coin_sel == 2'(k)))) begin
                    if (r_inv[k] != 8'hFF) begin
                        r_inv[k] <= r_inv[k] + 8'd1;
                    end
                end else if (w_xfer && (r_coin_sel == 2'(k)) && !(refill && (refill_sel == 2'(k)))) begin
                    r_inv[k] <= r_inv[k] - 8'd1;
                end
            end
        end
    end

    // A denomination is usable only while its stock is non-zero
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_avail[k] = (r_inv[k] != 8'd0);
        end
    end
`else
    // Unlimited stock: every denomination is always usable
    assign w_avail = 4'hF;
`endif

    coin_select #(
        .COIN3_VAL (COIN3_VAL),
        .COIN2_VAL (COIN2_VAL),
        .COIN1_VAL (COIN1_VAL),
        .COIN0_VAL (COIN0_VAL)
    ) u_coin_select (
        .i_remaining (r_remaining),
        .i_avail     (w_avail),
        .o_sel       (w_sel),
        .o_found     (w_found)
    );

    // Face value of the coin currently being offered
    always_comb begin
        w_coin_val = 8'(COIN0_VAL);
        case (r_coin_sel)
            2'd3:    w_coin_val = 8'(COIN3_VAL);
            2'd2:    w_coin_val = 8'(COIN2_VAL);
            2'd1:    w_coin_val = 8'(COIN1_VAL);
            default: w_coin_val = 8'(COIN0_VAL);
        endcase
    end

    assign w_gap_last = (int'(r_gap_cnt) >= (GAP_CYCLES - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_bad_balance = 1'b0;
        w_latch       = 1'b0;
        w_xfer        = 1'b0;
        w_shortage    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    if (balance > 8'(MAX_BALANCE)) begin
                        w_bad_balance = 1'b1;
                        w_state_nxt   = DONE;
                    end else begin
                        w_state_nxt = SELECT;
                    end
                end
            end
            SELECT: begin
                if (r_remaining == 8'd0) begin
                    w_state_nxt = DONE;
                end else if (!w_found) begin
                    // Only reachable when stock has run out
                    w_shortage  = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_latch     = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (hopper_ready) begin
                    w_xfer      = 1'b1;
                    w_state_nxt = (GAP_CYCLES == 0) ? SELECT : GAP;
                end
            end
            GAP: begin
                if (w_gap_last) begin
                    w_state_nxt = SELECT;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Payout bookkeeping: load on accepted start, pick on SELECT, debit on transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_remaining  <= 8'd0;
            r_coin_count <= 4'd0;
            r_error      <= 1'b0;
            r_coin_sel   <= 2'd0;
        end else begin
            if (w_load) begin
                r_remaining  <= balance;
                r_coin_count <= 4'd0;
                r_error      <= w_bad_balance;
            end
            if (w_latch) begin
                r_coin_sel <= w_sel;
            end
            if (w_xfer) begin
                r_remaining <= r_remaining - w_coin_val;
                if (r_coin_count != 4'hF) begin
                    r_coin_count <= r_coin_count + 4'd1;
                end
            end
            if (w_shortage) begin
                r_error <= 1'b1;
            end
        end
    end

    // Settle counter runs only while in GAP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gap_cnt <= 8'd0;
        end else if (r_state == GAP) begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
        end else begin
            r_gap_cnt <= 8'd0;
        end
    end

    // Outputs decode straight from state so reset drops coin_valid immediately
    assign coin_valid = (r_state == ISSUE);
    assign busy       = (r_state == SELECT) || (r_state == ISSUE) || (r_state == GAP);
    assign done       = (r_state == DONE);
    assign coin_sel   = r_coin_sel;
    assign error      = r_error;
    assign remaining  = r_remaining;
    assign coin_count = r_coin_count;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser; inventory scenario included when CHANGE_INVENTORY_EN is defined.
// Latency: checks first-coin and zero-balance latency of two cycles.
// Backpressure: stalls the hopper and checks coin_sel is held.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] balance;
    logic       hopper_ready;
    logic       coin_valid;
    logic [1:0] coin_sel;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] remaining;
    logic [3:0] coin_count;
`ifdef CHANGE_INVENTORY_EN
    logic       refill;
    logic [1:0] refill_sel;
`endif

    change_dispenser u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .balance      (balance),
        .hopper_ready (hopper_ready),
`ifdef CHANGE_INVENTORY_EN
        .refill       (refill),
        .refill_sel   (refill_sel),
`endif
        .coin_valid   (coin_valid),
        .coin_sel     (coin_sel),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .remaining    (remaining),
        .coin_count   (coin_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int exp_q[$];
    int e_cnt, e_rem, e_err;
    int inv[4] = '{0, 0, 0, 0};
    int coin_val[4] = '{1, 5, 10, 20};
    bit use_inv = 1'b0;
    int n_vld = 0;
    bit prev_vld = 1'b0;
    bit prev_xfer = 1'b0;
    logic [1:0] prev_sel = 2'd0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Greedy reference model: queues expected coins, returns expected count/remaining/error
    task automatic plan(input int bal);
        int r;
        int s;
        e_cnt = 0;
        e_err = 0;
        e_rem = bal;
        if (bal > 79) begin
            e_err = 1;
            return;
        end
        r = bal;
        while (r > 0) begin
            s = -1;
            for (int k = 3; k >= 0; k--) begin
                if (s < 0 && coin_val[k] <= r && (!use_inv || inv[k] > 0)) s = k;
            end
            if (s < 0) begin
                e_err = 1;
                break;
            end
            exp_q.push_back(s);
            r = r - coin_val[s];
            if (use_inv) inv[s] = inv[s] - 1;
            if (e_cnt < 15) e_cnt++;
        end
        e_rem = r;
    endtask

    // Transfer monitor: every accepted coin is popped from the scoreboard
    always @(negedge clk) begin
        if (coin_valid) n_vld++;
        if (coin_valid && prev_vld && !prev_xfer) check_val("sel_hold", coin_sel, prev_sel);
        if (coin_valid && hopper_ready) begin
            if (exp_q.size() == 0) check_val("extra_coin", 1, 0);
            else check_val("coin_sel", coin_sel, exp_q.pop_front());
        end
        prev_vld  = coin_valid;
        prev_xfer = coin_valid && hopper_ready;
        prev_sel  = coin_sel;
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after start was sampled
    task automatic start_payout(input int bal, input bit model);
        if (model) plan(bal);
        start   = 1'b1;
        balance = 8'(bal);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input bit chk_rem);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check_val("done_seen", seen, 1);
        if (seen) begin
            check_val("busy_in_done", busy, 0);
            check_val("error", error, e_err);
            if (chk_rem) check_val("remaining", remaining, e_rem);
            check_val("coin_count", coin_count, e_cnt);
            check_val("coins_pending", exp_q.size(), 0);
            @(negedge clk);
            check_val("done_one_cycle", done, 0);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_vld(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (coin_valid) seen = 1'b1;
        end
        check_val(tag, seen, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_coin_valid"}, coin_valid, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_error"}, error, 0);
        check_val({tag, "_remaining"}, remaining, 0);
        check_val({tag, "_coin_count"}, coin_count, 0);
        check_val({tag, "_coin_sel"}, coin_sel, 0);
    endtask

`ifdef CHANGE_INVENTORY_EN
    task automatic do_refill(input int sel);
        refill     = 1'b1;
        refill_sel = 2'(sel);
        inv[sel]   = inv[sel] + 1;
        @(posedge clk);
        #1 refill = 1'b0;
    endtask
`endif

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        balance      = 8'd0;
        hopper_ready = 1'b1;
`ifdef CHANGE_INVENTORY_EN
        refill       = 1'b0;
        refill_sel   = 2'd0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

`ifndef CHANGE_INVENTORY_EN
        // 37 -> 20,10,5,1,1
        start_payout(37, 1'b1);
        wait_done(1'b1);

        // Zero balance: done two cycles after start, no coin offered
        n_vld = 0;
        start_payout(0, 1'b1);
        @(posedge clk);
        #1;
        check_val("zero_done_latency", done, 1);
        check_val("zero_no_valid", coin_valid, 0);
        @(posedge clk);
        #1;
        check_val("zero_done_pulse", done, 0);
        check_val("zero_valid_count", n_vld, 0);
        exp_q.delete();

        // 79 with the hopper stalled on the first coin
        hopper_ready = 1'b0;
        start_payout(79, 1'b1);
        @(posedge clk);
        #1;
        check_val("first_coin_latency", coin_valid, 1);
        check_val("first_coin_sel", coin_sel, 3);
        repeat (5) @(posedge clk);
        #1 hopper_ready = 1'b1;
        wait_done(1'b1);

        // Second start mid-payout of 25 must be ignored
        start_payout(25, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        start   = 1'b1;
        balance = 8'd79;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(1'b1);

        // Illegal balance
        start_payout(80, 1'b1);
        wait_done(1'b0);

        // Reset while the second coin of 30 is being offered
        start_payout(30, 1'b1);
        wait_vld("first_coin_30");
        @(posedge clk);
        #1 hopper_ready = 1'b0;
        wait_vld("second_coin_30");
        check_val("second_coin_sel", coin_sel, 2);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_all_zero("midrst");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst          = 1'b0;
        hopper_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_val("idle_after_rst_busy", busy, 0);
        check_val("idle_after_rst_valid", coin_valid, 0);
        @(posedge clk);
        #1;
`else
        // Inventory {20:0, 10:4, 5:1, 1:2}
        use_inv = 1'b1;
        for (int i = 0; i < 4; i++) do_refill(2);
        do_refill(1);
        do_refill(0);
        do_refill(0);
        start_payout(40, 1'b1);
        wait_done(1'b1);
        // 8 with only 5:1, 1:2 left -> 5,1,1 then shortage
        start_payout(8, 1'b1);
        wait_done(1'b1);
        check_val("short_remaining", remaining, 1);
        check_val("short_error_sticky", error, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
